// File: rtl/exp_sum_buffer_16_if.sv
// Handshake bundle for exp_sum_buffer_16: exp-stage input side and
// divider output side, seen from the buffer (slave) and its driver (master).
interface exp_sum_buffer_16_if #(
    parameter int data_size = 16,
    parameter int sum_size  = 22
);
    logic [data_size-1:0] exp_data_i;
    logic                 exp_data_valid_i;
    logic                 exp_done_i;
    logic                 div_ready_i;
    logic [sum_size-1:0]  sum_data_o;
    logic                 sum_valid_o;
    logic [data_size-1:0] div_data_o;
    logic                 div_data_valid_o;
    logic                 div_last_o;
    logic [6:0]           count_o;
    logic                 overflow_o;

    modport slave (
        input  exp_data_i, exp_data_valid_i, exp_done_i, div_ready_i,
        output sum_data_o, sum_valid_o, div_data_o, div_data_valid_o,
        output div_last_o, count_o, overflow_o
    );

    modport master (
        output exp_data_i, exp_data_valid_i, exp_done_i, div_ready_i,
        input  sum_data_o, sum_valid_o, div_data_o, div_data_valid_o,
        input  div_last_o, count_o, overflow_o
    );
endinterface

// File: rtl/exp_sum_buffer_16.sv
// Buffers a vector of exp values while summing them, then streams the
// stored values to the divider alongside the held sum.
module exp_sum_buffer_16 #(
    parameter int data_size = 16,
    parameter int depth     = 64,
    parameter int sum_size  = 22
) (
    input  logic                 clock_i,
    input  logic                 reset_n_i,
    exp_sum_buffer_16_if.slave   bus
);
    localparam int         AW      = $clog2(depth);
    localparam int         PAD     = sum_size - data_size;
    localparam logic [6:0] DEPTH_C = 7'(depth);

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        STREAM,
        WAIT_REARM
    } state_t;

    state_t               state_q;
    logic [sum_size-1:0]  sum_q;
    logic [6:0]           count_q;
    logic [6:0]           rd_ptr_q;
    logic                 ovf_q;
    logic                 sum_valid_q;
    logic                 div_valid_q;
    logic                 div_last_q;
    logic [data_size-1:0] div_data_q;
    logic [data_size-1:0] mem_q [depth];

    logic                 acc_w;
    logic [sum_size-1:0]  sum_d;
    logic [6:0]           count_d;
    logic [6:0]           rd_nxt_w;

    // accept decision and the resulting sum/count for this cycle
    always_comb begin
        acc_w = 1'b0;
        if (bus.exp_data_valid_i) begin
            if (state_q == IDLE)
                acc_w = 1'b1;
            else if (state_q == ACCUM && count_q != DEPTH_C)
                acc_w = 1'b1;
        end
        sum_d    = acc_w ? sum_q + {{PAD{1'b0}}, bus.exp_data_i} : sum_q;
        count_d  = acc_w ? count_q + 7'd1 : count_q;
        rd_nxt_w = rd_ptr_q + 7'd1;
    end

    // element storage; contents are meaningless until written
    always_ff @(posedge clock_i) begin
        if (acc_w)
            mem_q[count_q[AW-1:0]] <= bus.exp_data_i;
    end

    // control FSM with registered outputs
    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q     <= IDLE;
            sum_q       <= '0;
            count_q     <= '0;
            rd_ptr_q    <= '0;
            ovf_q       <= 1'b0;
            sum_valid_q <= 1'b0;
            div_valid_q <= 1'b0;
            div_last_q  <= 1'b0;
            div_data_q  <= '0;
        end else begin
            if (bus.exp_data_valid_i && !acc_w)
                ovf_q <= 1'b1;
            unique case (state_q)
                IDLE: begin
                    sum_q   <= sum_d;
                    count_q <= count_d;
                    if (acc_w)
                        state_q <= ACCUM;
                    else if (bus.exp_done_i && count_q == 7'd0)
                        state_q <= WAIT_REARM;
                end
                ACCUM: begin
                    sum_q   <= sum_d;
                    count_q <= count_d;
                    if (bus.exp_done_i) begin
                        state_q     <= STREAM;
                        rd_ptr_q    <= '0;
                        sum_valid_q <= 1'b1;
                        div_valid_q <= 1'b1;
                        div_data_q  <= mem_q[0];
                        div_last_q  <= (count_d == 7'd1);
                    end
                end
                STREAM: begin
                    if (bus.div_ready_i) begin
                        rd_ptr_q <= rd_nxt_w;
                        if (div_last_q) begin
                            state_q     <= WAIT_REARM;
                            sum_valid_q <= 1'b0;
                            div_valid_q <= 1'b0;
                            div_last_q  <= 1'b0;
                        end else begin
                            div_data_q <= mem_q[rd_nxt_w[AW-1:0]];
                            div_last_q <= (rd_nxt_w + 7'd1 == count_q);
                        end
                    end
                end
                WAIT_REARM: begin
                    if (!bus.exp_done_i) begin
                        state_q  <= IDLE;
                        sum_q    <= '0;
                        count_q  <= '0;
                        rd_ptr_q <= '0;
                    end
                end
            endcase
        end
    end

    assign bus.sum_data_o       = sum_q;
    assign bus.sum_valid_o      = sum_valid_q;
    assign bus.div_data_o       = div_data_q;
    assign bus.div_data_valid_o = div_valid_q;
    assign bus.div_last_o       = div_last_q;
    assign bus.count_o          = count_q;
    assign bus.overflow_o       = ovf_q;
endmodule

// File: tb/tb_exp_sum_buffer_16.sv
// Scoreboard bench for exp_sum_buffer_16: directed vectors push expected
// stream elements; a negedge monitor pops and compares on each handshake.
module tb_exp_sum_buffer_16;
    typedef struct {
        logic [15:0] data;
        logic        last;
    } elem_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;
    logic [21:0] exp_sum = '0;
    elem_t exp_q[$];

    exp_sum_buffer_16_if #(.data_size(16), .sum_size(22)) bus ();

    exp_sum_buffer_16 #(.data_size(16), .depth(64), .sum_size(22)) dut (
        .clock_i   (clk),
        .reset_n_i (rst_n),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    function automatic void check(string nm, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endfunction

    function automatic void push(logic [15:0] d, logic l);
        elem_t e;
        e.data = d;
        e.last = l;
        exp_q.push_back(e);
    endfunction

    // monitor: compares presented elements and the held sum
    always @(negedge clk) begin
        if (rst_n && bus.div_data_valid_o) begin
            check("sum_valid", 32'(bus.sum_valid_o), 32'd1);
            check("sum_data", 32'(bus.sum_data_o), 32'(exp_sum));
            if (exp_q.size() == 0) begin
                if (bus.div_ready_i) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_elem: got 0x%0h expected none at %0t",
                             bus.div_data_o, $time);
                end
            end else begin
                check("div_data", 32'(bus.div_data_o), 32'(exp_q[0].data));
                check("div_last", 32'(bus.div_last_o), 32'(exp_q[0].last));
                if (bus.div_ready_i)
                    void'(exp_q.pop_front());
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic dv(input logic [15:0] d);
        bus.exp_data_valid_i = 1'b1;
        bus.exp_data_i       = d;
        step();
        bus.exp_data_valid_i = 1'b0;
    endtask

    task automatic wait_idle(input int maxc);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || bus.div_data_valid_o) && n < maxc) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (n >= maxc) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
            exp_q.delete();
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        bus.exp_data_valid_i = 1'b0;
        bus.exp_done_i       = 1'b0;
        bus.div_ready_i      = 1'b0;
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic rearm();
        bus.exp_done_i = 1'b0;
        step();
        check("rearm_count", 32'(bus.count_o), 32'd0);
        check("rearm_sum", 32'(bus.sum_data_o), 32'd0);
    endtask

    task automatic basic_vec();
        push(16'h8000, 1'b0);
        push(16'h4000, 1'b0);
        push(16'hFFFF, 1'b1);
        exp_sum = 22'h1BFFF;
        dv(16'h8000);
        dv(16'h4000);
        dv(16'hFFFF);
        bus.exp_done_i = 1'b1;
        check("pre_done_valid", 32'(bus.div_data_valid_o), 32'd0);
        step();
        check("lat_div_valid", 32'(bus.div_data_valid_o), 32'd1);
        check("lat_sum_valid", 32'(bus.sum_valid_o), 32'd1);
        check("basic_count", 32'(bus.count_o), 32'd3);
    endtask

    logic bp_pat [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};

    initial begin
        bus.exp_data_i       = '0;
        bus.exp_data_valid_i = 1'b0;
        bus.exp_done_i       = 1'b0;
        bus.div_ready_i      = 1'b0;
        #2;
        check("rst_sum", 32'(bus.sum_data_o), 32'd0);
        check("rst_sum_valid", 32'(bus.sum_valid_o), 32'd0);
        check("rst_div_valid", 32'(bus.div_data_valid_o), 32'd0);
        check("rst_count", 32'(bus.count_o), 32'd0);
        check("rst_ovf", 32'(bus.overflow_o), 32'd0);
        do_reset();

        // basic vector, divider always ready
        basic_vec();
        bus.div_ready_i = 1'b1;
        wait_idle(20);
        check("basic_sum_valid_drop", 32'(bus.sum_valid_o), 32'd0);
        check("basic_count_hold", 32'(bus.count_o), 32'd3);
        rearm();

        // backpressure pattern 1,0,0,1,1
        bus.div_ready_i = 1'b0;
        basic_vec();
        for (int i = 0; i < 5; i++) begin
            bus.div_ready_i = bp_pat[i];
            step();
        end
        wait_idle(20);
        check("bp_ovf", 32'(bus.overflow_o), 32'd0);
        rearm();

        // full: 65 valids, the last one dropped
        for (int i = 0; i < 64; i++)
            push(16'hFFFF, i == 63);
        exp_sum = 22'h3FFFC0;
        for (int i = 0; i < 65; i++)
            dv(16'hFFFF);
        bus.exp_done_i = 1'b1;
        step();
        check("full_count", 32'(bus.count_o), 32'd64);
        check("full_ovf", 32'(bus.overflow_o), 32'd1);
        check("full_sum", 32'(bus.sum_data_o), 32'h3FFFC0);
        wait_idle(100);
        rearm();
        check("ovf_sticky", 32'(bus.overflow_o), 32'd1);

        do_reset();
        check("ovf_cleared", 32'(bus.overflow_o), 32'd0);

        // last valid together with done
        push(16'h0200, 1'b0);
        push(16'h0100, 1'b1);
        exp_sum = 22'h300;
        dv(16'h0200);
        bus.exp_done_i = 1'b1;
        dv(16'h0100);
        check("sim_div_valid", 32'(bus.div_data_valid_o), 32'd1);
        check("sim_count", 32'(bus.count_o), 32'd2);
        check("sim_sum", 32'(bus.sum_data_o), 32'h300);
        bus.div_ready_i = 1'b1;
        wait_idle(20);

        // waiting for re-arm: valid dropped, overflow raised
        check("wait_count", 32'(bus.count_o), 32'd2);
        check("wait_ovf_pre", 32'(bus.overflow_o), 32'd0);
        dv(16'h1234);
        check("wait_ovf", 32'(bus.overflow_o), 32'd1);
        check("wait_count_hold", 32'(bus.count_o), 32'd2);
        check("wait_div_valid", 32'(bus.div_data_valid_o), 32'd0);
        rearm();
        push(16'h0010, 1'b0);
        push(16'h0020, 1'b1);
        exp_sum = 22'h30;
        dv(16'h0010);
        dv(16'h0020);
        bus.exp_done_i = 1'b1;
        step();
        check("rearm2_sum", 32'(bus.sum_data_o), 32'h30);
        check("rearm2_count", 32'(bus.count_o), 32'd2);
        wait_idle(20);
        rearm();

        // reset during streaming after one handshake
        do_reset();
        push(16'h1111, 1'b0);
        push(16'h2222, 1'b0);
        push(16'h3333, 1'b1);
        exp_sum = 22'h6666;
        dv(16'h1111);
        dv(16'h2222);
        dv(16'h3333);
        bus.exp_done_i = 1'b1;
        step();
        bus.div_ready_i = 1'b1;
        step();
        check("mid_popped", 32'(exp_q.size()), 32'd2);
        bus.div_ready_i = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_sum", 32'(bus.sum_data_o), 32'd0);
        check("mid_sum_valid", 32'(bus.sum_valid_o), 32'd0);
        check("mid_div_valid", 32'(bus.div_data_valid_o), 32'd0);
        check("mid_div_data", 32'(bus.div_data_o), 32'd0);
        check("mid_div_last", 32'(bus.div_last_o), 32'd0);
        check("mid_count", 32'(bus.count_o), 32'd0);
        exp_q.delete();
        step();
        rst_n = 1'b1;
        bus.exp_done_i  = 1'b0;
        bus.div_ready_i = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            check("post_rst_div_valid", 32'(bus.div_data_valid_o), 32'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
